// File: rtl/fifo_fwft_stream_framer.sv
// Drains a wide first-word-fall-through FIFO in whole packets of PKT_WORDS words
// and presents them on a valid/ready stream with a last-beat marker.
module fifo_fwft_stream_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_WORDS  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_has_data,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  busy
);

  localparam int                   IDX_WIDTH = $clog2(PKT_WORDS + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(PKT_WORDS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  word_idx;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_data, skid_data;
  logic                  head_last, skid_last;
  logic                  push, pull, push_last;

  assign push      = fifo_rd_en;
  assign pull      = m_valid && m_ready;
  assign push_last = (word_idx == LAST_IDX);

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_data;
  assign m_last  = head_last;

  // The pop decision looks only at registered state and the FIFO flag, never at m_ready.
  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    busy       = (occ != 2'd0);
    case (state)
      IDLE: begin
        if (en && fifo_has_data) state_nxt = STREAM;
      end
      STREAM: begin
        busy       = 1'b1;
        fifo_rd_en = !fifo_empty && (occ < 2'd2);
        if (fifo_rd_en && push_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_idx  <= '0;
      pkt_count <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register updates from pre-edge values.
      state <= state_nxt;
      if (push) word_idx <= push_last ? '0 : word_idx + IDX_WIDTH'(1);
      if (pull && head_last) pkt_count <= pkt_count + CNT_WIDTH'(1);
    end
  end

  // Two-entry buffer: head feeds the stream, skid absorbs the word popped under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so m_data reads 0 straight out of reset.
      occ       <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else begin
      case ({push, pull})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= fifo_rd_data;
            head_last <= push_last;
          end else begin
            skid_data <= fifo_rd_data;
            skid_last <= push_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_data <= skid_data;
          head_last <= skid_last;
          occ       <= occ - 2'd1;
        end
        // Push needs occ<2 and pull needs occ>0, so both together means occ==1.
        2'b11: begin
          head_data <= fifo_rd_data;
          head_last <= push_last;
        end
        default: ;
      endcase
    end
  end

endmodule
